// File: rtl/brightness_pkg.sv
// Shared types and helpers for the brightness datapath writers.
package brightness_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE_ST} wb_state_t;

  localparam int PE_W  = 16;
  localparam int PIX_W = 8;

  // Clamp a signed lane to the unsigned pixel range.
  function automatic logic [PIX_W-1:0] lane_sat(input logic signed [PE_W-1:0] x);
    if (x[PE_W-1])
      return '0;
    else if (|x[PE_W-2:PIX_W])
      return '1;
    else
      return x[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/result_ram_writer_pixel_saturator.sv
// Combinational clamp of one signed array lane to an unsigned RAM pixel.
module pixel_saturator #(
  parameter int PE_DATA_WIDTH  = 16,
  parameter int RAM_DATA_WIDTH = 8
) (
  input  logic [PE_DATA_WIDTH-1:0]  lane_in,
  output logic [RAM_DATA_WIDTH-1:0] pixel_out
);

  always_comb begin
    if (lane_in[PE_DATA_WIDTH-1])
      pixel_out = '0;
    else if (|lane_in[PE_DATA_WIDTH-2:RAM_DATA_WIDTH])
      pixel_out = '1;
    else
      pixel_out = lane_in[RAM_DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/result_ram_writer.sv
// Write-back end of the brightness datapath: buffers result vectors and
// writes saturated pixels sequentially into the output RAM.
module result_ram_writer
  import brightness_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int PE_DATA_WIDTH  = 16,
  parameter int DEPTH          = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0]   data_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]        ram_address,
  output logic [RAM_DATA_WIDTH-1:0]        ram_wdata,
  output logic                             busy,
  output logic                             done
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]             LAST_LANE = CW'(DEPTH - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] STEP      = RAM_ADDR_WIDTH'(DEPTH);
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_BASE = RAM_ADDR_WIDTH'((1 << RAM_ADDR_WIDTH) - DEPTH);

  wb_state_t                     state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0]     base_addr_q, base_addr_d;
  logic [CW-1:0]                 word_counter_q, word_counter_d;
  logic [PE_DATA_WIDTH-1:0]      lane_buf_q [DEPTH];
  logic [PE_DATA_WIDTH-1:0]      lane_buf_d [DEPTH];

  logic                          last_lane, last_block, transfer;
  logic [RAM_DATA_WIDTH-1:0]     sat_pixel;

  assign last_lane  = (word_counter_q == LAST_LANE);
  assign last_block = (base_addr_q == LAST_BASE);
  assign transfer   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      base_addr_q    <= '0;
      word_counter_q <= '0;
      for (int i = 0; i < DEPTH; i++) lane_buf_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      base_addr_q    <= base_addr_d;
      word_counter_q <= word_counter_d;
      lane_buf_q     <= lane_buf_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_addr_d    = base_addr_q;
    word_counter_d = word_counter_q;
    lane_buf_d     = lane_buf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = ARMED;
          base_addr_d    = '0;
          word_counter_d = '0;
        end
      end
      ARMED: begin
        if (transfer) state_d = WRITE;
      end
      WRITE: begin
        if (last_lane) begin
          word_counter_d = '0;
          base_addr_d    = base_addr_q + STEP;
          // A vector accepted on the last lane keeps WRITE going with no bubble.
          if (last_block)     state_d = DONE_ST;
          else if (!transfer) state_d = ARMED;
        end else begin
          word_counter_d = word_counter_q + CW'(1);
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (transfer) begin
      for (int i = 0; i < DEPTH; i++)
        lane_buf_d[i] = data_in[i*PE_DATA_WIDTH +: PE_DATA_WIDTH];
    end
  end

  pixel_saturator #(
    .PE_DATA_WIDTH (PE_DATA_WIDTH),
    .RAM_DATA_WIDTH(RAM_DATA_WIDTH)
  ) u_sat (
    .lane_in  (lane_buf_q[word_counter_q]),
    .pixel_out(sat_pixel)
  );

  // Outputs decode registers only, so reset clears them without a clock edge.
  always_comb begin
    in_ready    = (state_q == ARMED) || ((state_q == WRITE) && last_lane && !last_block);
    ram_we      = (state_q == WRITE);
    ram_address = ram_we ? (base_addr_q + RAM_ADDR_WIDTH'(word_counter_q)) : '0;
    ram_wdata   = ram_we ? sat_pixel : '0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE_ST);
  end

endmodule
